sonar_ranger: RTL and testbench
===============================

SONAR_RANGER -- requirements
Module: sonar_ranger

Interface
REQ-001 Parameter CLK_HZ, default 25_000_000: system clock frequency, documentation only, not used in logic.
REQ-002 Parameter TRIG_CYCLES, default 275: trig pulse width in clk cycles (11 us).
REQ-003 Parameter PERIOD_CYCLES, default 1_048_576: clk cycles between successive trig rising edges.
REQ-004 Parameter CYC_PER_CM, default 1450: clk cycles of echo high per centimetre (58 us).
REQ-005 Parameter ECHO_WAIT_MAX, default 50_000: max clk cycles from trig falling edge to echo rise.
REQ-006 Parameter DIST_W, default 9: distance width in cm.
REQ-007 Parameters MIN_CM, default 2, and MAX_CM, default 400: in_range window, inclusive.
REQ-008 Parameter AVG_LOG2, default 0, legal 0..3: moving-average depth 2^AVG_LOG2 samples.
REQ-009 clk  in  1  system clock; all logic on rising edge.
REQ-010 rst_n  in  1  asynchronous active-low reset.
REQ-011 enable  in  1  level; 1 = run periodic measurements.
REQ-012 echo  in  1  asynchronous sensor echo.
REQ-013 trig  out  1  sensor trigger pulse.
REQ-014 distance  out  DIST_W  averaged distance in cm.
REQ-015 dist_valid  out  1  one-cycle pulse; distance/in_range just updated.
REQ-016 in_range  out  1  last accepted distance within [MIN_CM, MAX_CM].
REQ-017 timeout  out  1  one-cycle pulse; measurement aborted.
REQ-018 busy  out  1  high in any state except IDLE.

Function
REQ-019 echo SHALL pass a 2-flop synchronizer; all edge detection uses the synchronized value (echo_s); latency 2 cycles.
REQ-020 FSM states: IDLE, TRIG, WAIT_ECHO, MEASURE, HOLDOFF.
REQ-021 IDLE -> TRIG when enable=1; a period counter SHALL clear on TRIG entry and count every cycle thereafter.
REQ-022 trig SHALL be 1 only in TRIG, for exactly TRIG_CYCLES cycles; then -> WAIT_ECHO.
REQ-023 WAIT_ECHO -> MEASURE on echo_s rising edge; echo_s already high on entry is not a rising edge.
REQ-024 WAIT_ECHO with ECHO_WAIT_MAX cycles elapsed and no rising edge -> HOLDOFF with timeout pulse.
REQ-025 MEASURE: prescaler counts 0..CYC_PER_CM-1 while echo_s=1; on wrap cm counter +1; echo_s falling edge -> HOLDOFF, sample = cm counter (truncated).
REQ-026 cm counter reaching 2^DIST_W-1 in MEASURE SHALL abort -> HOLDOFF with timeout pulse, no sample.
REQ-027 Period counter reaching PERIOD_CYCLES-1 in any state except HOLDOFF SHALL abort -> HOLDOFF with timeout pulse.
REQ-028 HOLDOFF: when period counter reaches PERIOD_CYCLES-1 -> TRIG if enable=1, else IDLE.
REQ-029 enable deasserted mid-cycle SHALL NOT abort; the current cycle completes.
REQ-030 Accepted sample SHALL be written into a 2^AVG_LOG2-deep circular buffer with running sum; distance = sum >> AVG_LOG2.
REQ-031 First accepted sample after reset SHALL fill every buffer slot.
REQ-032 dist_valid, distance and in_range SHALL update together exactly 2 cycles after the falling-edge detection cycle.
REQ-033 in_range SHALL be computed on the averaged distance; a timeout SHALL clear in_range and leave distance unchanged.
REQ-034 dist_valid and timeout SHALL never assert in the same cycle.

Reset
REQ-035 rst_n=0 SHALL immediately force IDLE, trig=0, distance=0, dist_valid=0, in_range=0, timeout=0, busy=0, and clear all counters, buffer and synchronizer.
REQ-036 Reset mid-measurement SHALL discard the partial sample; after release the first trig follows enable=1 within 1 cycle of IDLE.

Verification
REQ-037 Defaults, enable=1, echo high 14_500 cycles after 1000-cycle delay -> trig high 275 cycles; distance=10, in_range=1, one dist_valid pulse.
REQ-038 echo high 1449 cycles -> distance=0, dist_valid pulse, in_range=0.
REQ-039 echo never rises -> timeout pulse 50_000 cycles after trig falls; distance unchanged, in_range=0; next trig at 1_048_576-cycle spacing.
REQ-040 echo stuck high -> cm saturation at 511, timeout pulse, no dist_valid.
REQ-041 AVG_LOG2=2, samples 100,100,100,200 cm -> distance 100,100,100,125.
REQ-042 enable dropped during MEASURE -> sample completes and reports, then IDLE, busy=0; rst_n pulse during MEASURE -> all outputs 0 next edge.

Source files
------------

// File: rtl/sonar_ranger.sv
// -----------------------------------------------------------------------------
// sonar_ranger
//
// Periodic driver for an HC-SR04 style ultrasonic ranger. Every PERIOD_CYCLES
// clocks it fires a TRIG_CYCLES wide trigger pulse, times the returning echo
// pulse in whole centimetres (CYC_PER_CM clocks per cm), and reports a moving
// average over 2^AVG_LOG2 accepted samples.
//
// Ports
//   clk        in   system clock, all logic on the rising edge
//   rst_n      in   asynchronous active-low reset
//   enable     in   level; 1 = keep running measurement cycles
//   echo       in   asynchronous echo line from the sensor
//   trig       out  trigger pulse to the sensor
//   distance   out  averaged distance in cm
//   dist_valid out  one-cycle pulse: distance and in_range just updated
//   in_range   out  last accepted distance lies in [MIN_CM, MAX_CM]
//   timeout    out  one-cycle pulse: the current measurement was aborted
//   busy       out  high whenever the FSM is not in IDLE
//
// Result signalling: there is no back-pressure. dist_valid and timeout are
// single-cycle strobes that are never high together; distance/in_range are
// held between strobes and may be sampled at any time.
// -----------------------------------------------------------------------------
module sonar_ranger #(
    parameter int CLK_HZ        = 25_000_000,
    parameter int TRIG_CYCLES   = 275,
    parameter int PERIOD_CYCLES = 1_048_576,
    parameter int CYC_PER_CM    = 1450,
    parameter int ECHO_WAIT_MAX = 50_000,
    parameter int DIST_W        = 9,
    parameter int MIN_CM        = 2,
    parameter int MAX_CM        = 400,
    parameter int AVG_LOG2      = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic              echo,
    output logic              trig,
    output logic [DIST_W-1:0] distance,
    output logic              dist_valid,
    output logic              in_range,
    output logic              timeout,
    output logic              busy
);

    // One shared counter serves as trigger-width timer, echo-wait timer and
    // cm prescaler, so it must hold the largest of the three limits.
    localparam int CNT_MAX_A = (TRIG_CYCLES > ECHO_WAIT_MAX) ? TRIG_CYCLES : ECHO_WAIT_MAX;
    localparam int CNT_MAX   = (CNT_MAX_A > CYC_PER_CM) ? CNT_MAX_A : CYC_PER_CM;
    localparam int CNT_W     = $clog2(CNT_MAX + 1);
    localparam int PER_W     = $clog2(PERIOD_CYCLES + 1);
    localparam int DEPTH     = 1 << AVG_LOG2;
    localparam int PTR_W     = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
    localparam int NSLOT     = 1 << PTR_W;
    localparam int SUM_W     = DIST_W + AVG_LOG2;

    localparam logic [CNT_W-1:0]  TRIG_LAST = CNT_W'(TRIG_CYCLES - 1);
    localparam logic [CNT_W-1:0]  WAIT_LAST = CNT_W'(ECHO_WAIT_MAX - 1);
    localparam logic [CNT_W-1:0]  CPC_LAST  = CNT_W'(CYC_PER_CM - 1);
    localparam logic [PER_W-1:0]  PER_LAST  = PER_W'(PERIOD_CYCLES - 1);
    localparam logic [DIST_W-1:0] CM_SAT    = {DIST_W{1'b1}};
    localparam logic [DIST_W-1:0] MIN_V     = DIST_W'(MIN_CM);
    localparam logic [DIST_W-1:0] MAX_V     = DIST_W'(MAX_CM);
    localparam logic [PTR_W-1:0]  PTR_LAST  = PTR_W'(DEPTH - 1);

    // CLK_HZ is documentation only.
    localparam logic [31:0] CLK_HZ_BITS = CLK_HZ;
    logic clk_hz_unused;
    assign clk_hz_unused = ^CLK_HZ_BITS;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_TRIG      = 3'd1,
        ST_WAIT_ECHO = 3'd2,
        ST_MEASURE   = 3'd3,
        ST_HOLDOFF   = 3'd4
    } state_t;

    // ---------------------------------------------------------------- state
    state_t              state_q, state_d;
    logic                echo_meta_q, echo_meta_d;
    logic                echo_s_q, echo_s_d;
    logic                echo_prev_q, echo_prev_d;
    logic [PER_W-1:0]    period_q, period_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [DIST_W-1:0]   cm_q, cm_d;
    logic                timeout_q, timeout_d;
    logic                smp_vld_q, smp_vld_d;
    logic [DIST_W-1:0]   smp_q, smp_d;

    logic [DIST_W-1:0]   buf_q [NSLOT];
    logic [DIST_W-1:0]   buf_d [NSLOT];
    logic [SUM_W-1:0]    sum_q, sum_d;
    logic [PTR_W-1:0]    wr_q, wr_d;
    logic                filled_q, filled_d;
    logic [DIST_W-1:0]   distance_q, distance_d;
    logic                in_range_q, in_range_d;
    logic                dist_valid_q, dist_valid_d;

    logic echo_rise;
    logic echo_fall;
    logic period_last;
    logic [PTR_W-1:0] wr_next;

    // ------------------------------------------------------- synchronizer
    always_comb begin
        echo_meta_d = echo;
        echo_s_d    = echo_meta_q;
        echo_prev_d = echo_s_q;
    end

    assign echo_rise   = echo_s_q & ~echo_prev_q;
    assign echo_fall   = ~echo_s_q & echo_prev_q;
    assign period_last = (period_q == PER_LAST);

    // ------------------------------------------------------------------ FSM
    always_comb begin
        state_d   = state_q;
        period_d  = period_q + 1'b1;
        cnt_d     = cnt_q;
        cm_d      = cm_q;
        timeout_d = 1'b0;
        smp_vld_d = 1'b0;
        smp_d     = smp_q;

        case (state_q)
            ST_IDLE: begin
                period_d = '0;
                cnt_d    = '0;
                if (enable) begin
                    state_d = ST_TRIG;
                end
            end

            ST_TRIG: begin
                cnt_d = cnt_q + 1'b1;
                if (period_last) begin
                    state_d   = ST_HOLDOFF;
                    timeout_d = 1'b1;
                end else if (cnt_q == TRIG_LAST) begin
                    state_d = ST_WAIT_ECHO;
                    cnt_d   = '0;
                end
            end

            ST_WAIT_ECHO: begin
                cnt_d = cnt_q + 1'b1;
                if (period_last) begin
                    state_d   = ST_HOLDOFF;
                    timeout_d = 1'b1;
                end else if (echo_rise) begin
                    // The rising-edge cycle is itself the first high cycle of
                    // the echo, so it is counted as the first prescaler step.
                    state_d = ST_MEASURE;
                    if (CYC_PER_CM == 1) begin
                        cnt_d = '0;
                        cm_d  = DIST_W'(1);
                    end else begin
                        cnt_d = CNT_W'(1);
                        cm_d  = '0;
                    end
                end else if (cnt_q == WAIT_LAST) begin
                    state_d   = ST_HOLDOFF;
                    timeout_d = 1'b1;
                end
            end

            ST_MEASURE: begin
                if (period_last || (cm_q == CM_SAT)) begin
                    state_d   = ST_HOLDOFF;
                    timeout_d = 1'b1;
                end else if (echo_fall) begin
                    state_d   = ST_HOLDOFF;
                    smp_vld_d = 1'b1;
                    smp_d     = cm_q;
                end else if (cnt_q == CPC_LAST) begin
                    cnt_d = '0;
                    cm_d  = cm_q + 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            ST_HOLDOFF: begin
                if (period_last) begin
                    if (enable) begin
                        state_d  = ST_TRIG;
                        period_d = '0;
                        cnt_d    = '0;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------- averaging datapath
    assign wr_next = (wr_q == PTR_LAST) ? '0 : wr_q + 1'b1;

    always_comb begin
        buf_d        = buf_q;
        sum_d        = sum_q;
        wr_d         = wr_q;
        filled_d     = filled_q;
        distance_d   = distance_q;
        in_range_d   = in_range_q;
        dist_valid_d = 1'b0;

        if (smp_vld_q) begin
            if (!filled_q) begin
                // First sample after reset primes the whole window so the
                // average starts at the real value instead of ramping from 0.
                for (int i = 0; i < DEPTH; i++) begin
                    buf_d[i] = smp_q;
                end
                sum_d    = SUM_W'(smp_q) << AVG_LOG2;
                filled_d = 1'b1;
            end else begin
                buf_d[wr_q] = smp_q;
                sum_d       = sum_q - SUM_W'(buf_q[wr_q]) + SUM_W'(smp_q);
            end
            wr_d         = wr_next;
            distance_d   = DIST_W'(sum_d >> AVG_LOG2);
            in_range_d   = (distance_d >= MIN_V) && (distance_d <= MAX_V);
            dist_valid_d = 1'b1;
        end else if (timeout_d) begin
            in_range_d = 1'b0;
        end
    end

    // ------------------------------------------------------------ registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            echo_meta_q  <= 1'b0;
            echo_s_q     <= 1'b0;
            echo_prev_q  <= 1'b0;
            period_q     <= '0;
            cnt_q        <= '0;
            cm_q         <= '0;
            timeout_q    <= 1'b0;
            smp_vld_q    <= 1'b0;
            smp_q        <= '0;
            for (int i = 0; i < NSLOT; i++) begin
                buf_q[i] <= '0;
            end
            sum_q        <= '0;
            wr_q         <= '0;
            filled_q     <= 1'b0;
            distance_q   <= '0;
            in_range_q   <= 1'b0;
            dist_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            echo_meta_q  <= echo_meta_d;
            echo_s_q     <= echo_s_d;
            echo_prev_q  <= echo_prev_d;
            period_q     <= period_d;
            cnt_q        <= cnt_d;
            cm_q         <= cm_d;
            timeout_q    <= timeout_d;
            smp_vld_q    <= smp_vld_d;
            smp_q        <= smp_d;
            buf_q        <= buf_d;
            sum_q        <= sum_d;
            wr_q         <= wr_d;
            filled_q     <= filled_d;
            distance_q   <= distance_d;
            in_range_q   <= in_range_d;
            dist_valid_q <= dist_valid_d;
        end
    end

    // -------------------------------------------------------------- outputs
    assign trig       = (state_q == ST_TRIG);
    assign busy       = (state_q != ST_IDLE);
    assign distance   = distance_q;
    assign dist_valid = dist_valid_q;
    assign in_range   = in_range_q;
    assign timeout    = timeout_q;

endmodule

// File: tb/tb_sonar_ranger.sv
// -----------------------------------------------------------------------------
// tb_sonar_ranger
//
// Directed bench for sonar_ranger with shrunk timing parameters:
// 5-cycle trig, 400-cycle period, 4 cycles per cm, 60-cycle echo wait,
// 5-bit distance (saturates at 31), window [2,20], 4-deep average.
// An echo held high for N cycles therefore reads floor(N/4) cm.
// -----------------------------------------------------------------------------
module tb_sonar_ranger;

    localparam int DW = 5;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          enable;
    logic          echo;
    logic          trig;
    logic [DW-1:0] distance;
    logic          dist_valid;
    logic          in_range;
    logic          timeout;
    logic          busy;

    int total  = 0;
    int passed = 0;
    int cyc    = 0;

    sonar_ranger #(
        .CLK_HZ       (25_000_000),
        .TRIG_CYCLES  (5),
        .PERIOD_CYCLES(400),
        .CYC_PER_CM   (4),
        .ECHO_WAIT_MAX(60),
        .DIST_W       (DW),
        .MIN_CM       (2),
        .MAX_CM       (20),
        .AVG_LOG2     (2)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .enable    (enable),
        .echo      (echo),
        .trig      (trig),
        .distance  (distance),
        .dist_valid(dist_valid),
        .in_range  (in_range),
        .timeout   (timeout),
        .busy      (busy)
    );

    // ------------------------------------------------------ clock and reset
    always #5 clk = ~clk;
    always @(posedge clk) cyc = cyc + 1;

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic apply_reset();
        rst_n  = 1'b0;
        enable = 1'b0;
        echo   = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
    endtask

    // -------------------------------------------------------- driver tasks
    task automatic wait_trig_rise(output int t);
        int n = 0;
        while (trig !== 1'b1 && n < 1000) begin
            tick();
            n++;
        end
        t = cyc;
        total++;
        if (trig !== 1'b1) $display("FAIL trig_rise: trig=%b after %0d cycles, required 1", trig, n);
        else passed++;
    endtask

    task automatic wait_trig_low(output int width);
        width = 0;
        while (trig === 1'b1 && width < 100) begin
            tick();
            width++;
        end
        total++;
        if (trig !== 1'b0) $display("FAIL trig_fall: trig=%b after %0d cycles, required 0", trig, width);
        else passed++;
    endtask

    // One full measurement: echo rises dly cycles after trig falls and stays
    // high for `high` cycles. Reports trig width, strobe counts, the tick
    // (after the echo drop) on which dist_valid appeared, and the result.
    task automatic measure(input int dly, input int high, output int tw, output int nv,
                           output int nt, output int lat, output logic [DW-1:0] d,
                           output logic r);
        int t;
        nv = 0; nt = 0; lat = -1; d = '0; r = 1'b0;
        wait_trig_rise(t);
        wait_trig_low(tw);
        repeat (dly) tick();
        echo = 1'b1;
        for (int i = 0; i < high + 12; i++) begin
            if (i == high) echo = 1'b0;
            tick();
            if (dist_valid === 1'b1) begin
                nv++;
                d   = distance;
                r   = in_range;
                lat = i - high + 1;
            end
            if (timeout === 1'b1) nt++;
        end
    endtask

    // ---------------------------------------------------------------- tests
    task automatic test_reset();
        rst_n  = 1'b0;
        enable = 1'b0;
        echo   = 1'b0;
        repeat (3) tick();
        total++; if (trig !== 1'b0) $display("FAIL reset_trig: got %b want 0", trig); else passed++;
        total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else passed++;
        total++; if (distance !== 5'd0) $display("FAIL reset_distance: got %0d want 0", distance); else passed++;
        total++; if (dist_valid !== 1'b0) $display("FAIL reset_dist_valid: got %b want 0", dist_valid); else passed++;
        total++; if (in_range !== 1'b0) $display("FAIL reset_in_range: got %b want 0", in_range); else passed++;
        total++; if (timeout !== 1'b0) $display("FAIL reset_timeout: got %b want 0", timeout); else passed++;
        rst_n = 1'b1;
        repeat (3) tick();
        total++; if (busy !== 1'b0) $display("FAIL idle_when_disabled: busy=%b want 0", busy); else passed++;
    endtask

    task automatic test_basic();
        int tw, nv, nt, lat;
        logic [DW-1:0] d;
        logic r;
        apply_reset();
        enable = 1'b1;
        measure(10, 40, tw, nv, nt, lat, d, r);
        total++; if (tw != 5) $display("FAIL trig_width: got %0d want 5", tw); else passed++;
        total++; if (nv != 1) $display("FAIL basic_valid_count: got %0d want 1", nv); else passed++;
        total++; if (nt != 0) $display("FAIL basic_timeout_count: got %0d want 0", nt); else passed++;
        total++; if (d !== 5'd10) $display("FAIL basic_distance: got %0d want 10", d); else passed++;
        total++; if (r !== 1'b1) $display("FAIL basic_in_range: got %b want 1", r); else passed++;
        total++; if (lat != 4) $display("FAIL valid_latency: got %0d want 4", lat); else passed++;
    endtask

    task automatic test_zero_cm();
        int tw, nv, nt, lat;
        logic [DW-1:0] d;
        logic r;
        apply_reset();
        enable = 1'b1;
        measure(3, 3, tw, nv, nt, lat, d, r);
        total++; if (nv != 1) $display("FAIL zero_valid_count: got %0d want 1", nv); else passed++;
        total++; if (d !== 5'd0) $display("FAIL zero_distance: got %0d want 0", d); else passed++;
        total++; if (r !== 1'b0) $display("FAIL zero_in_range: got %b want 0", r); else passed++;
    endtask

    task automatic test_window_edges();
        int highs [4] = '{80, 84, 8, 7};
        int exp_d [4] = '{20, 21, 2, 1};
        logic exp_r [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
        int tw, nv, nt, lat;
        logic [DW-1:0] d;
        logic r;
        for (int k = 0; k < 4; k++) begin
            apply_reset();
            enable = 1'b1;
            measure(5, highs[k], tw, nv, nt, lat, d, r);
            total++;
            if (d !== DW'(exp_d[k])) $display("FAIL window_distance[%0d]: got %0d want %0d", k, d, exp_d[k]);
            else passed++;
            total++;
            if (r !== exp_r[k]) $display("FAIL window_in_range[%0d]: got %b want %b", k, r, exp_r[k]);
            else passed++;
        end
    endtask

    task automatic test_echo_timeout();
        int tw, nv, nt, lat, t1, t2, n;
        logic [DW-1:0] d;
        logic r;
        apply_reset();
        enable = 1'b1;
        measure(10, 40, tw, nv, nt, lat, d, r);
        total++; if (d !== 5'd10) $display("FAIL pre_timeout_distance: got %0d want 10", d); else passed++;
        wait_trig_rise(t1);
        wait_trig_low(tw);
        n = 0; nv = 0;
        while (timeout !== 1'b1 && n < 200) begin
            tick();
            n++;
            if (dist_valid === 1'b1) nv++;
        end
        total++; if (n != 60) $display("FAIL wait_timeout_delay: got %0d want 60", n); else passed++;
        total++; if (distance !== 5'd10) $display("FAIL timeout_distance: got %0d want 10", distance); else passed++;
        total++; if (in_range !== 1'b0) $display("FAIL timeout_in_range: got %b want 0", in_range); else passed++;
        total++; if (nv != 0) $display("FAIL timeout_no_valid: got %0d want 0", nv); else passed++;
        tick();
        total++; if (timeout !== 1'b0) $display("FAIL timeout_one_cycle: got %b want 0", timeout); else passed++;
        wait_trig_rise(t2);
        total++; if (t2 - t1 != 400) $display("FAIL trig_period: got %0d want 400", t2 - t1); else passed++;
    endtask

    task automatic test_stuck_high();
        int t, tw, n, nv;
        apply_reset();
        enable = 1'b1;
        wait_trig_rise(t);
        wait_trig_low(tw);
        echo = 1'b1;
        n = 0; nv = 0;
        while (timeout !== 1'b1 && n < 300) begin
            tick();
            n++;
            if (dist_valid === 1'b1) nv++;
        end
        total++; if (n != 127) $display("FAIL saturation_delay: got %0d want 127", n); else passed++;
        total++; if (nv != 0) $display("FAIL saturation_no_valid: got %0d want 0", nv); else passed++;
        total++; if (distance !== 5'd0) $display("FAIL saturation_distance: got %0d want 0", distance); else passed++;
        total++; if (in_range !== 1'b0) $display("FAIL saturation_in_range: got %b want 0", in_range); else passed++;
        echo = 1'b0;
    endtask

    task automatic test_back_to_back_average();
        int highs [5] = '{32, 32, 32, 64, 64};
        int exp_d [5] = '{8, 8, 8, 10, 12};
        int tw, nv, nt, lat;
        logic [DW-1:0] d;
        logic r;
        apply_reset();
        enable = 1'b1;
        for (int k = 0; k < 5; k++) begin
            measure(5, highs[k], tw, nv, nt, lat, d, r);
            total++;
            if (nv != 1 || d !== DW'(exp_d[k]))
                $display("FAIL average[%0d]: got %0d (pulses %0d) want %0d (pulses 1)", k, d, nv, exp_d[k]);
            else passed++;
        end
    endtask

    task automatic test_enable_drop();
        int t, tw, nv, n, ntrig;
        logic [DW-1:0] d;
        apply_reset();
        enable = 1'b1;
        wait_trig_rise(t);
        wait_trig_low(tw);
        repeat (10) tick();
        echo = 1'b1;
        repeat (20) tick();
        enable = 1'b0;
        repeat (20) tick();
        echo = 1'b0;
        nv = 0; d = '0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (dist_valid === 1'b1) begin
                nv++;
                d = distance;
            end
        end
        total++; if (nv != 1) $display("FAIL drop_valid_count: got %0d want 1", nv); else passed++;
        total++; if (d !== 5'd10) $display("FAIL drop_distance: got %0d want 10", d); else passed++;
        n = 0; ntrig = 0;
        while (busy !== 1'b0 && n < 600) begin
            tick();
            n++;
            if (trig === 1'b1) ntrig++;
        end
        total++; if (busy !== 1'b0) $display("FAIL drop_goes_idle: busy=%b want 0", busy); else passed++;
        repeat (50) begin
            tick();
            if (trig === 1'b1 || busy === 1'b1) ntrig++;
        end
        total++; if (ntrig != 0) $display("FAIL drop_no_retrigger: got %0d active cycles want 0", ntrig); else passed++;
    endtask

    task automatic test_reset_mid_measure();
        int t, tw, nv, nt, lat;
        logic [DW-1:0] d;
        logic r;
        enable = 1'b1;
        measure(5, 40, tw, nv, nt, lat, d, r);
        total++; if (d !== 5'd10) $display("FAIL rerun_distance: got %0d want 10", d); else passed++;
        wait_trig_rise(t);
        wait_trig_low(tw);
        repeat (5) tick();
        echo = 1'b1;
        repeat (20) tick();
        rst_n = 1'b0;
        #1;
        total++; if (busy !== 1'b0) $display("FAIL midrst_busy: got %b want 0", busy); else passed++;
        total++; if (trig !== 1'b0) $display("FAIL midrst_trig: got %b want 0", trig); else passed++;
        total++; if (distance !== 5'd0) $display("FAIL midrst_distance: got %0d want 0", distance); else passed++;
        total++; if (in_range !== 1'b0) $display("FAIL midrst_in_range: got %b want 0", in_range); else passed++;
        total++; if (dist_valid !== 1'b0 || timeout !== 1'b0)
            $display("FAIL midrst_strobes: got valid=%b timeout=%b want 0 0", dist_valid, timeout);
        else passed++;
        echo = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        total++; if (trig !== 1'b1) $display("FAIL restart_trig: got %b want 1", trig); else passed++;
        nv = 0;
        repeat (20) begin
            tick();
            if (dist_valid === 1'b1) nv++;
        end
        total++; if (nv != 0) $display("FAIL partial_discarded: got %0d pulses want 0", nv); else passed++;
    endtask

    // ------------------------------------------------------------- sequence
    initial begin
        rst_n  = 1'b0;
        enable = 1'b0;
        echo   = 1'b0;
        test_reset();
        test_basic();
        test_zero_cm();
        test_window_edges();
        test_echo_timeout();
        test_stuck_high();
        test_back_to_back_average();
        test_enable_drop();
        test_reset_mid_measure();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
